// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the memory sequencer: FSM state encoding, bus widths
// and the default bus timeout.
package mem_sequencer_pkg;

    localparam int DATA_W          = 32;
    localparam int ADDR_W          = 30;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        DATA   = 3'd2,
        COMMIT = 3'd3,
        FAULT  = 3'd4
    } state_e;

    // Byte address rounded down to its containing word.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
        return a & ~DATA_W'(3);
    endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Single-port memory bus between the sequencer (master) and the memory (slave).
interface mem_sequencer_if;
    import mem_sequencer_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_sequencer_wait_timer.sv
// Per-request wait counter: counts unacknowledged request cycles and flags the
// final permitted cycle so the sequencer can abandon the request on that edge.
module wait_timer
    import mem_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The TIMEOUT-th waiting cycle is the last one; the request drops on its edge.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_sequencer.sv
// Instruction/data memory sequencer: fetches an instruction, optionally performs
// one load or store, then lets the CPU commit for one cycle before the next fetch.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_next_pc,
    input  logic              cpu_dreq,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] rdata,
    output logic              E,
    output logic              bus_err,
    mem_sequencer_if.master   mem
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic ack;
    logic tmr_clear;
    logic tmr_en;
    logic tmr_expired;

    // An acknowledge only counts while a request is actually outstanding.
    assign ack    = mem_req_q && mem.mem_ack;
    assign tmr_en = mem_req_q && !mem.mem_ack;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            FETCH: begin
                if (!mem_req_q) begin
                    // Only reached straight out of reset; later fetches are raised by COMMIT.
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q[DATA_W-1:2];
                end else if (ack) begin
                    instr_d   = mem.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = EXEC;
                end
            end

            EXEC: begin
                if (cpu_dreq) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    state_d     = DATA;
                end else begin
                    state_d = COMMIT;
                end
            end

            DATA: begin
                if (ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = COMMIT;
                end
            end

            COMMIT: begin
                // Raise the next fetch here so a zero-wait fetch completes in one cycle.
                pc_d       = word_align(cpu_next_pc);
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_d[DATA_W-1:2];
                state_d    = FETCH;
            end

            FAULT: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end

            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = FAULT;
            end
        endcase

        if (tmr_expired) begin
            bus_err_d = 1'b1;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = FAULT;
        end
    end

    assign tmr_clear = (state_d != state_q) && ((state_d == FETCH) || (state_d == DATA));

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign instr         = instr_q;
    assign pc            = pc_q;
    assign rdata         = rdata_q;
    assign bus_err       = bus_err_q;
    assign E             = (state_q != COMMIT);
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: a memory responder, a monitor popping
// expected bus transfers and commits, and a directed stimulus sequence.
`timescale 1ns/1ps
module tb_mem_sequencer;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } xfer_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rdata;
        int          gap;
    } commit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_next_pc;
    logic        cpu_dreq = 1'b0;
    logic        cpu_we = 1'b0;
    logic [29:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] instr, pc, rdata;
    logic        E, bus_err;

    mem_sequencer_if bus();

    mem_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_next_pc (cpu_next_pc),
        .cpu_dreq    (cpu_dreq),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .instr       (instr),
        .pc          (pc),
        .rdata       (rdata),
        .E           (E),
        .bus_err     (bus_err),
        .mem         (bus)
    );

    always #10 clk = ~clk;

    // CPU model: next pc is either sequential or a fixed (halt) target.
    logic        npc_fix_en = 1'b0;
    logic [31:0] npc_fix = '0;
    assign cpu_next_pc = npc_fix_en ? npc_fix : pc + 32'd4;

    int checks = 0;
    int failures = 0;
    int n_commits = 0;
    int n_wr_acks = 0;
    bit we_seen = 1'b0;
    xfer_t   xq[$];
    commit_t cq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_x(input logic we, input logic [29:0] addr, input logic [31:0] wd, input bit cw);
        xfer_t x;
        x.we = we; x.addr = addr; x.wdata = wd; x.chk_wd = cw;
        xq.push_back(x);
    endtask

    task automatic push_c(input logic [31:0] p, input logic [31:0] i, input logic [31:0] r, input int g);
        commit_t c;
        c.pc = p; c.instr = i; c.rdata = r; c.gap = g;
        cq.push_back(c);
    endtask

    // Memory responder: instruction words are {2'b11, word address}; word 0x10 holds DEADBEEF.
    bit ack_tied = 1'b1;
    bit never_ack = 1'b0;
    int wr_delay = 0;
    int ld_delay = 0;
    initial begin
        int wcnt;
        int dly;
        wcnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk); #1;
            if (ack_tied) begin
                bus.mem_ack = 1'b1;
            end else if (never_ack || !bus.mem_req) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else begin
                dly = bus.mem_we ? wr_delay : ((bus.mem_addr == 30'h10) ? ld_delay : 0);
                if (wcnt >= dly) begin
                    bus.mem_ack = 1'b1;
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end
            bus.mem_rdata = (bus.mem_addr == 30'h10) ? 32'hDEAD_BEEF : {2'b11, bus.mem_addr};
        end
    end

    // Monitor: accepted transfers, request stability, and commit cycles.
    initial begin
        int          cyc;
        int          last_cyc;
        logic        prev_req;
        logic        prev_ack;
        logic [63:0] prev_bus;
        xfer_t       x;
        commit_t     c;
        cyc = 0; last_cyc = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_bus = '0;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (!rst) begin
                if (bus.mem_we) we_seen = 1'b1;
                if (bus.mem_req && bus.mem_ack) begin
                    if (bus.mem_we) n_wr_acks++;
                    if (xq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL xfer_unexpected actual_addr=%0h required=none", bus.mem_addr);
                    end else begin
                        x = xq.pop_front();
                        chk("xfer_we", 64'(bus.mem_we), 64'(x.we));
                        chk("xfer_addr", 64'(bus.mem_addr), 64'(x.addr));
                        if (x.chk_wd) chk("xfer_wdata", 64'(bus.mem_wdata), 64'(x.wdata));
                    end
                end
                if (prev_req && !prev_ack && !bus_err)
                    chk("req_stable", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, prev_bus);
                if (!E) begin
                    if (cq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL commit_unexpected actual_pc=%0h required=none", pc);
                    end else begin
                        c = cq.pop_front();
                        chk("commit_pc", 64'(pc), 64'(c.pc));
                        chk("commit_instr", 64'(instr), 64'(c.instr));
                        chk("commit_rdata", 64'(rdata), 64'(c.rdata));
                        if (c.gap != 0) chk("commit_gap", 64'(cyc - last_cyc), 64'(c.gap));
                    end
                    last_cyc = cyc;
                    n_commits++;
                end
            end
            prev_req = bus.mem_req;
            prev_ack = bus.mem_ack;
            prev_bus = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        end
    end

    task automatic step();
        @(negedge clk); #3;
    endtask

    task automatic wait_commits(input int target, input int budget);
        int n;
        n = 0;
        while (n_commits < target && n < budget) begin
            step();
            n++;
        end
        if (n_commits < target) begin
            checks++; failures++;
            $display("FAIL commit_wait actual=%0d required=%0d", n_commits, target);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, 64'(pc), 64'h0);
        chk({tag, "_instr"}, 64'(instr), 64'h0);
        chk({tag, "_rdata"}, 64'(rdata), 64'h0);
        chk({tag, "_E_buserr"}, {62'h0, E, bus_err}, 64'h2);
        chk({tag, "_bus"}, {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'h0);
    endtask

    initial begin
        int  n;
        bit  found;

        // Reset, then three plain instructions with ack tied high.
        rst = 1'b1;
        repeat (2) step();
        check_reset("init");
        push_x(1'b0, 30'h0, '0, 1'b0);
        push_x(1'b0, 30'h1, '0, 1'b0);
        push_x(1'b0, 30'h2, '0, 1'b0);
        push_c(32'h0, 32'hC000_0000, 32'h0, 0);
        push_c(32'h4, 32'hC000_0001, 32'h0, 3);
        push_c(32'h8, 32'hC000_0002, 32'h0, 3);
        rst = 1'b0;
        step();
        chk("first_req", 64'(bus.mem_req), 64'h1);
        wait_commits(3, 30);
        chk("no_write_plain", 64'(we_seen), 64'h0);

        // Load from word 0x10.
        ack_tied = 1'b0;
        cpu_dreq = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h10; cpu_wdata = 32'h0;
        push_x(1'b0, 30'h3, '0, 1'b0);
        push_x(1'b0, 30'h10, 32'h0, 1'b1);
        push_c(32'hC, 32'hC000_0003, 32'hDEAD_BEEF, 4);
        wait_commits(4, 20);

        // Store with three wait states.
        cpu_we = 1'b1; cpu_addr = 30'h22; cpu_wdata = 32'h1234_5678; wr_delay = 3;
        n_wr_acks = 0;
        push_x(1'b0, 30'h4, '0, 1'b0);
        push_x(1'b1, 30'h22, 32'h1234_5678, 1'b1);
        push_c(32'h10, 32'hC000_0004, 32'hDEAD_BEEF, 7);
        wait_commits(5, 30);
        chk("store_ack_count", 64'(n_wr_acks), 64'h1);

        // Halt: next pc fixed at 0x20, applied by the commit in progress.
        cpu_dreq = 1'b0; cpu_we = 1'b0; wr_delay = 0;
        npc_fix_en = 1'b1; npc_fix = 32'h20;
        for (int i = 0; i < 3; i++) begin
            push_x(1'b0, 30'h8, '0, 1'b0);
            push_c(32'h20, 32'hC000_0008, 32'hDEAD_BEEF, 3);
        end
        wait_commits(8, 30);
        chk("halt_pc", 64'(pc), 64'h20);

        // Timeout: no ack on the next fetch.
        never_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_err) break;
            if (bus.mem_req) n++;
        end
        chk("timeout_req_cycles", 64'(n), 64'd16);
        chk("timeout_state", {61'h0, bus_err, bus.mem_req, E}, 64'h5);
        ack_tied = 1'b1;
        never_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("fault_hold", {61'h0, E, bus.mem_req, bus_err}, 64'h5);
        end
        chk("fault_pc", 64'(pc), 64'h20);

        // Reset out of FAULT, then abort a load while it waits in DATA.
        ack_tied = 1'b0;
        rst = 1'b1;
        step();
        check_reset("fault_rst");
        cpu_dreq = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h10; cpu_wdata = 32'h0;
        ld_delay = 8;
        npc_fix_en = 1'b0;
        push_x(1'b0, 30'h0, '0, 1'b0);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_req && bus.mem_addr == 30'h10) begin
                found = 1'b1;
                break;
            end
        end
        chk("data_wait_seen", 64'(found), 64'h1);
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("async_req_drop", 64'(bus.mem_req), 64'h0);
        chk("abort_rdata", 64'(rdata), 64'h0);
        step();
        check_reset("mid_data");
        cpu_dreq = 1'b0;
        push_x(1'b0, 30'h0, '0, 1'b0);
        push_c(32'h0, 32'hC000_0000, 32'h0, 0);
        rst = 1'b0;
        wait_commits(9, 20);

        chk("xfer_queue_empty", 64'(xq.size()), 64'h0);
        chk("commit_queue_empty", 64'(cq.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
